// File: rtl/sam_vid_pkg.sv
// Shared types and widths for the SAM Coupe video fetch sequencer.
package sam_vid_pkg;

    localparam int unsigned VID_ADDR_W = 25;
    localparam int unsigned VID_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE
    } vf_state_t;

endpackage

// File: rtl/sam_vid_fifo.sv
// First-word fall-through FIFO that accepts zero, one or two words per cycle.
// Head reads as zero while empty so the pixel port shows a clean value.
module sam_vid_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_flush,
    input  logic [1:0]               i_push,
    input  logic [WIDTH-1:0]         i_wdata0,
    input  logic [WIDTH-1:0]         i_wdata1,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_free_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_V = DEPTH[PW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic [PW:0]      w_count;
    logic [PW:0]      w_push_n;
    logic [PW-1:0]    w_wr_idx1;
    logic             w_pop_ok;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_push_n   = {{(PW - 1){1'b0}}, i_push};
    assign w_wr_idx1  = r_wr_ptr[PW-1:0] + 1'b1;
    assign w_pop_ok   = i_pop && !o_empty;
    assign o_empty    = (w_count == '0);
    assign o_full     = (w_count == DEPTH_V);
    assign o_free_cnt = DEPTH_V - w_count;
    assign o_head     = o_empty ? '0 : r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + w_push_n;
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge i_clk) begin
        if (i_push != 2'd0) begin
            r_mem[r_wr_ptr[PW-1:0]] <= i_wdata0;
        end
        if (i_push == 2'd2) begin
            r_mem[w_wr_idx1] <= i_wdata1;
        end
    end

endmodule

// File: rtl/sam_vid_fetch.sv
// Video line fetch sequencer: drives the SDRAM video read ports and queues captured words.
// Define SAM_VID_DUAL_EN for paired two-channel fetch; otherwise only channel 1 is used.
module sam_vid_fetch
    import sam_vid_pkg::*;
#(
    parameter int unsigned FETCH_WAIT = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_line_start,
    input  logic [VID_ADDR_W-1:0] i_line_base,
    input  logic [7:0]            i_line_words,
    output logic [VID_ADDR_W-1:0] o_vid_addr1,
    output logic [VID_ADDR_W-1:0] o_vid_addr2,
    input  logic [VID_DATA_W-1:0] i_vid_data1,
    input  logic [VID_DATA_W-1:0] i_vid_data2,
    output logic [VID_DATA_W-1:0] o_pix_data,
    output logic                  o_pix_valid,
    input  logic                  i_pix_rd,
    output logic                  o_line_done,
    output logic                  o_underflow
);

`ifdef SAM_VID_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    localparam int unsigned FPW = $clog2(FIFO_DEPTH);
    localparam logic [FPW:0] FREE_NEED = DUAL ? 2 : 1;
    localparam logic [7:0] WAIT_INIT = 8'(FETCH_WAIT - 1);
    localparam logic [VID_ADDR_W-1:0] ADDR_STEP = DUAL ? 25'd4 : 25'd2;
    localparam logic [VID_ADDR_W-1:0] ADDR2_RST = 25'd2;

    vf_state_t             r_state;
    logic [VID_ADDR_W-1:0] r_cur;
    logic [7:0]            r_rem;
    logic [7:0]            r_wait_cnt;
    logic [VID_ADDR_W-1:0] r_addr1;
    logic [VID_ADDR_W-1:0] r_addr2;
    logic                  r_pend;
    logic [VID_ADDR_W-1:0] r_pend_base;
    logic [7:0]            r_pend_words;
    logic                  r_line_done;
    logic                  r_underflow;

    logic [VID_ADDR_W-1:0] w_base_in;
    logic [VID_ADDR_W-1:0] w_next2;
    logic                  w_same;
    logic                  w_push_two;
    logic [7:0]            w_step_words;
    logic [1:0]            w_push;
    logic                  w_flush;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic [FPW:0]          w_free_cnt;
    logic                  w_can_issue;
    logic [VID_ADDR_W-1:0] w_rs_base;
    logic [7:0]            w_rs_words;

    assign w_base_in    = {i_line_base[VID_ADDR_W-1:1], 1'b0};
    assign w_next2      = r_cur + 25'd2;
    // Unchanged addresses are not refetched by the controller; its held data is already valid.
    assign w_same       = (r_addr1 == r_cur) && (!DUAL || (r_addr2 == w_next2));
    assign w_push_two   = DUAL && (r_rem >= 8'd2);
    assign w_step_words = w_push_two ? 8'd2 : 8'd1;
    assign w_push       = (r_state == STORE && !i_line_start) ? (w_push_two ? 2'd2 : 2'd1) : 2'd0;
    assign w_flush      = i_line_start && ((r_state != IDLE) || (i_line_words != 8'd0));
    assign w_can_issue  = !w_fifo_full && (w_free_cnt >= FREE_NEED);
    assign w_rs_base    = i_line_start ? w_base_in : r_pend_base;
    assign w_rs_words   = i_line_start ? i_line_words : r_pend_words;

    sam_vid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (VID_DATA_W)
    ) u_fifo (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_flush    (w_flush),
        .i_push     (w_push),
        .i_wdata0   (i_vid_data1),
        .i_wdata1   (i_vid_data2),
        .i_pop      (i_pix_rd),
        .o_head     (o_pix_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_free_cnt (w_free_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_rem        <= '0;
            r_wait_cnt   <= '0;
            r_addr1      <= '0;
            r_addr2      <= ADDR2_RST;
            r_pend       <= 1'b0;
            r_pend_base  <= '0;
            r_pend_words <= '0;
            r_line_done  <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_line_done <= 1'b0;
            if (i_line_start) begin
                r_underflow <= 1'b0;
            end else if (i_pix_rd && w_fifo_empty) begin
                r_underflow <= 1'b1;
            end

            if (i_line_start && r_state != WAIT) begin
                r_pend <= 1'b0;
                if (i_line_words != 8'd0) begin
                    r_cur   <= w_base_in;
                    r_rem   <= i_line_words;
                    r_state <= ISSUE;
                end else begin
                    r_state <= IDLE;
                end
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    ISSUE: begin
                        if (w_can_issue) begin
                            r_addr1 <= r_cur;
                            if (DUAL) begin
                                r_addr2 <= w_next2;
                            end
                            if (w_same) begin
                                r_state <= STORE;
                            end else begin
                                r_wait_cnt <= WAIT_INIT;
                                r_state    <= WAIT;
                            end
                        end
                    end
                    WAIT: begin
                        // A restart here is deferred until the outstanding fetch has settled.
                        if (i_line_start) begin
                            r_pend       <= 1'b1;
                            r_pend_base  <= w_base_in;
                            r_pend_words <= i_line_words;
                        end
                        if (r_wait_cnt != 8'd0) begin
                            r_wait_cnt <= r_wait_cnt - 8'd1;
                        end else if (r_pend || i_line_start) begin
                            r_pend <= 1'b0;
                            if (w_rs_words != 8'd0) begin
                                r_cur   <= w_rs_base;
                                r_rem   <= w_rs_words;
                                r_state <= ISSUE;
                            end else begin
                                r_state <= IDLE;
                            end
                        end else begin
                            r_state <= STORE;
                        end
                    end
                    STORE: begin
                        r_cur <= r_cur + ADDR_STEP;
                        r_rem <= r_rem - w_step_words;
                        if (r_rem <= w_step_words) begin
                            r_line_done <= 1'b1;
                            r_state     <= IDLE;
                        end else begin
                            r_state <= ISSUE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign o_vid_addr1 = r_addr1;
    assign o_vid_addr2 = r_addr2;
    assign o_pix_valid = !w_fifo_empty;
    assign o_line_done = r_line_done;
    assign o_underflow = r_underflow;

endmodule

// File: tb/tb_sam_vid_fetch.sv
// Bench for sam_vid_fetch: SDRAM data model plus an expected-word queue per line.
module tb_sam_vid_fetch;

`ifdef SAM_VID_DUAL_EN
    localparam bit DUAL = 1'b1;
`else
    localparam bit DUAL = 1'b0;
`endif

    localparam int FW = 16;
    localparam int FD = 8;
    localparam int REP_WORDS = DUAL ? 2 : 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic [24:0] line_base = '0;
    logic [7:0]  line_words = '0;
    logic [24:0] o_vid_addr1;
    logic [24:0] o_vid_addr2;
    logic [15:0] vid_data1 = 16'h0;
    logic [15:0] vid_data2 = 16'h0;
    logic [15:0] o_pix_data;
    logic        o_pix_valid;
    logic        pix_rd = 1'b0;
    logic        o_line_done;
    logic        o_underflow;

    sam_vid_fetch #(
        .FETCH_WAIT (FW),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_line_start (line_start),
        .i_line_base  (line_base),
        .i_line_words (line_words),
        .o_vid_addr1  (o_vid_addr1),
        .o_vid_addr2  (o_vid_addr2),
        .i_vid_data1  (vid_data1),
        .i_vid_data2  (vid_data2),
        .o_pix_data   (o_pix_data),
        .o_pix_valid  (o_pix_valid),
        .i_pix_rd     (pix_rd),
        .o_line_done  (o_line_done),
        .o_underflow  (o_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] fdat(input logic [24:0] a);
        return a[15:0] ^ {a[22:16], 9'h000};
    endfunction

    // SDRAM controller model: data for a new address is garbage until FW cycles have passed.
    int          age1 = 1000;
    int          age2 = 1000;
    logic [24:0] seen1 = 25'h0;
    logic [24:0] seen2 = 25'h2;
    always @(negedge clk) begin
        if (o_vid_addr1 != seen1) begin
            seen1 = o_vid_addr1;
            age1 = 0;
        end else if (age1 < 1000) begin
            age1++;
        end
        if (o_vid_addr2 != seen2) begin
            seen2 = o_vid_addr2;
            age2 = 0;
        end else if (age2 < 1000) begin
            age2++;
        end
        vid_data1 = (age1 >= FW) ? fdat(seen1) : 16'hDEAD;
        vid_data2 = (age2 >= FW) ? fdat(seen2) : 16'hDEAD;
    end

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];
    int          done_seen = 0;
    int          done_cyc = 0;
    int          line_cyc = 0;
    int          npop = 0;
    logic [15:0] first_pop = 16'h0;

    typedef struct {
        logic [24:0] base;
        logic [7:0]  words;
        int          rd_pct;
        logic [15:0] exp_first;
        int          exp_pops;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic load_q(input logic [24:0] base, input logic [7:0] words);
        logic [24:0] a;
        exp_q.delete();
        a = {base[24:1], 1'b0};
        for (int i = 0; i < int'(words); i++) begin
            exp_q.push_back(fdat(a));
            a = a + 25'd2;
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic cycle(input int rd_pct, input bit ls, input logic [24:0] base,
                         input logic [7:0] words);
        if (!ls && o_line_done) begin
            done_seen++;
            if (done_seen == 1) done_cyc = line_cyc;
        end
        pix_rd = 1'b0;
        if (o_pix_valid && (int'($urandom_range(99, 0)) < rd_pct)) begin
            pix_rd = 1'b1;
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL extra_word: actual %0h required none", o_pix_data);
            end else begin
                if (npop == 0) first_pop = o_pix_data;
                chk("pop_data", {16'h0, o_pix_data}, {16'h0, exp_q.pop_front()});
            end
            npop++;
        end
        line_start = ls;
        if (ls) begin
            line_base = base;
            line_words = words;
            load_q(base, words);
        end
        @(negedge clk);
        line_start = 1'b0;
        pix_rd = 1'b0;
        line_cyc++;
    endtask

    task automatic start_line(input logic [24:0] base, input logic [7:0] words);
        done_seen = 0;
        npop = 0;
        line_cyc = 0;
        done_cyc = -1;
        first_pop = 16'h0;
        cycle(0, 1'b1, base, words);
    endtask

    task automatic finish_line(input int exp_pops, input int rd_pct);
        int budget;
        int n;
        budget = 500 + exp_pops * (FW + 2) * 4;
        n = 0;
        while (!(done_seen >= 1 && exp_q.size() == 0) && n < budget) begin
            cycle(rd_pct, 1'b0, '0, '0);
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL line_timeout: actual %0d pops required %0d", npop, exp_pops);
        end
        cycle(0, 1'b0, '0, '0);
        cycle(0, 1'b0, '0, '0);
        chk("line_done_count", done_seen, 1);
        chk("pop_count", npop, exp_pops);
        chk("drained_valid", o_pix_valid, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{25'h0010000, 8'd4,  100, 16'h0200, 4};
        tbl[1] = '{25'h0010001, 8'd3,  50,  16'h0200, 3};
        tbl[2] = '{25'h1FFFFFE, 8'd4,  80,  16'h01FE, 4};
        tbl[3] = '{25'h00ABCDE, 8'd1,  70,  16'hA8DE, 1};
        tbl[4] = '{25'h0000100, 8'd9,  30,  16'h0100, 9};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_addr1", o_vid_addr1, 25'h0);
        chk("rst_addr2", o_vid_addr2, 25'h2);
        chk("rst_pix_data", o_pix_data, 16'h0);
        chk("rst_pix_valid", o_pix_valid, 0);
        chk("rst_line_done", o_line_done, 0);
        chk("rst_underflow", o_underflow, 0);

        for (int i = 0; i < 5; i++) begin
            start_line(tbl[i].base, tbl[i].words);
            finish_line(tbl[i].exp_pops, tbl[i].rd_pct);
            chk("tbl_first_word", first_pop, tbl[i].exp_first);
        end

        // Address latency and pix_valid timing.
        start_line(25'h0040000, 8'd2);
        cycle(0, 1'b0, '0, '0);
        chk("issue_addr1", o_vid_addr1, 25'h0040000);
        chk("issue_addr2", o_vid_addr2, DUAL ? 25'h0040002 : 25'h2);
        repeat (FW) cycle(0, 1'b0, '0, '0);
        chk("valid_in_store", o_pix_valid, 0);
        cycle(0, 1'b0, '0, '0);
        chk("valid_after_store", o_pix_valid, 1);
        finish_line(2, 100);

        // Same line twice: the second one reuses the held data.
        start_line(25'h0, 8'(REP_WORDS));
        finish_line(REP_WORDS, 100);
        start_line(25'h0, 8'(REP_WORDS));
        finish_line(REP_WORDS, 100);
        chk("repeat_fast_done", (done_cyc >= 1 && done_cyc <= 4), 1);
        chk("repeat_first_word", first_pop, fdat(25'h0));

        // Restart while a fetch is outstanding.
        start_line(25'h0010000, 8'd8);
        cycle(0, 1'b0, '0, '0);
        cycle(0, 1'b0, '0, '0);
        start_line(25'h0020000, 8'd4);
        finish_line(4, 70);
        chk("abort_first_word", first_pop, 16'h0400);

        // Backpressure: no pops while the line is far longer than the FIFO.
        start_line(25'h0050000, 8'd32);
        repeat ((FD + 3) * (FW + 2)) cycle(0, 1'b0, '0, '0);
        chk("bp_no_done", done_seen, 0);
        chk("bp_valid", o_pix_valid, 1);
        finish_line(32, 100);

        // Underflow is sticky until the next line_start.
        pix_rd = 1'b1;
        @(negedge clk);
        pix_rd = 1'b0;
        chk("underflow_set", o_underflow, 1);
        @(negedge clk);
        chk("underflow_sticky", o_underflow, 1);
        start_line(25'h0060000, 8'd1);
        chk("underflow_clear", o_underflow, 0);
        finish_line(1, 100);

        // Zero-length line fetches nothing.
        start_line(25'h0070000, 8'd0);
        repeat (FW + 6) cycle(100, 1'b0, '0, '0);
        chk("zero_no_done", done_seen, 0);
        chk("zero_no_valid", o_pix_valid, 0);

        // Reset landing on the first STORE.
        start_line(25'h0030000, 8'd6);
        repeat (FW + 1) cycle(0, 1'b0, '0, '0);
        chk("pre_reset_valid", o_pix_valid, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_addr1", o_vid_addr1, 25'h0);
        chk("mid_rst_addr2", o_vid_addr2, 25'h2);
        chk("mid_rst_pix_data", o_pix_data, 16'h0);
        chk("mid_rst_pix_valid", o_pix_valid, 0);
        chk("mid_rst_line_done", o_line_done, 0);
        chk("mid_rst_underflow", o_underflow, 0);
        reset = 1'b0;
        exp_q.delete();
        done_seen = 0;
        repeat (FW + 6) cycle(100, 1'b0, '0, '0);
        chk("post_rst_no_done", done_seen, 0);
        chk("post_rst_empty", o_pix_valid, 0);

        // Random lines, some aborted part-way.
        for (int r = 0; r < 16; r++) begin
            logic [24:0] ba;
            logic [24:0] bb;
            logic [7:0]  wa;
            logic [7:0]  wb;
            int          k;
            int          pct;
            ba = 25'($urandom());
            bb = 25'($urandom());
            wa = 8'($urandom_range(12, 1));
            wb = 8'($urandom_range(12, 1));
            pct = int'($urandom_range(100, 30));
            k = int'($urandom_range(40, 0));
            start_line(ba, wa);
            for (int j = 0; j < k && done_seen == 0; j++) begin
                cycle(pct, 1'b0, '0, '0);
            end
            if (done_seen == 0 && !o_line_done && ($urandom_range(1, 0) == 1)) begin
                start_line(bb, wb);
                finish_line(int'(wb), pct);
            end else begin
                finish_line(int'(wa), pct);
            end
        end
        chk("final_underflow", o_underflow, 0);
        if (!DUAL) chk("single_addr2_held", o_vid_addr2, 25'h2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sam_vid_fetch.md
# sam_vid_fetch

Video fetch sequencer for the SAM Coupé core. It walks one display line of screen memory, drives the two video read ports of the SDRAM controller (`vid_addr1`/`vid_addr2`), and captures `vid_data1`/`vid_data2` after a fixed worst-case latency. Captured words go into a small FIFO that the pixel generator pops one word at a time.

## Interface

Parameters:
- `FETCH_WAIT`, 32: cycles from an address change to a guaranteed-valid capture. Covers the controller's worst case at ~100 MHz (refresh, then CPU access, then video). Range 8..255.
- `FIFO_DEPTH`, 8: FIFO depth in 16-bit words. Power of two, ≥4.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock (~100 MHz), the same clock as the SDRAM controller.
- `reset` in 1: synchronous active-high reset.
- `line_start` in 1: single-cycle pulse that begins a new line.
- `line_base` in 25: byte address of the first word, sampled on `line_start`. Bit 0 is ignored and forced to 0.
- `line_words` in 8: number of 16-bit words to fetch, sampled on `line_start`. A value of 0 means no fetch.
- `vid_addr1` out 25: channel-1 address to the SDRAM controller.
- `vid_addr2` out 25: channel-2 address to the SDRAM controller.
- `vid_data1` in 16: channel-1 data from the controller, held until its next fetch.
- `vid_data2` in 16: channel-2 data from the controller, held until its next fetch.
- `pix_data` out 16: FIFO head word.
- `pix_valid` out 1: FIFO is non-empty.
- `pix_rd` in 1: pop request. Ignored when `pix_valid`=0.
- `line_done` out 1: single-cycle pulse after the last word of the line is pushed.
- `underflow` out 1: sticky flag, set when `pix_rd` arrives while the FIFO is empty. Cleared by `line_start`.

## Operation

- Reset values:
  - `vid_addr1`=0, `vid_addr2`=2.
  - `pix_data`=0, `pix_valid`=0, `line_done`=0, `underflow`=0.
  - FIFO empty, state IDLE, word counter 0.
- FSM states are IDLE, ISSUE, WAIT and STORE.
- **IDLE:**
  - On `line_start` with `line_words`≠0: latch base and count, flush the FIFO, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE** (entered only when the FIFO has ≥2 free slots; otherwise stall in ISSUE):
  - Set `vid_addr1`=cur and `vid_addr2`=cur+2 (byte addresses, 25-bit wrap).
  - If both new addresses equal the currently driven values, go straight to STORE. The controller does not refetch an unchanged address, but the held data is already valid.
  - Otherwise load the wait counter with FETCH_WAIT−1 and go to WAIT.
- **WAIT:** decrement the counter; at 0, go to STORE.
- **STORE:**
  - Push `vid_data1`.
  - Push `vid_data2` if remaining ≥2. On an odd tail, push only `vid_data1`.
  - Advance cur by 4 and decrement remaining by 1 or 2.
  - If remaining reaches 0: pulse `line_done` and go to IDLE. Otherwise go to ISSUE.
- **`line_start` mid-line:**
  - In ISSUE or STORE: abort at once, flush the FIFO, then restart as in IDLE.
  - In WAIT: set a pending flag and flush the FIFO. Finish the wait, discard the data without pushing, then restart with the new parameters.
- **FIFO:**
  - Simultaneous push and pop are both performed.
  - The FIFO never overflows, because of the ISSUE free-slot check.
  - Pointers are log2(FIFO_DEPTH) bits with an extra wrap bit for full/empty.
- **`reset`** takes effect in any state and overrides `line_start`.

## Timing

- Address outputs are registered and change on the clock edge that enters WAIT.
- First capture happens FETCH_WAIT cycles after that edge.
- `pix_valid` rises the cycle after STORE.
- Steady-state throughput is 2 words per FETCH_WAIT+2 cycles. The same-address shortcut costs 2 cycles per pair.
- Pop: `pix_data` advances on the edge where `pix_rd`&`pix_valid`. FIFO read latency is 0 (first-word fall-through).
- `line_done` is asserted in the cycle after the final STORE.

## Configuration

- `SAM_VID_DUAL_EN` defined:
  - Two-channel paired fetch as described above.
- `SAM_VID_DUAL_EN` undefined:
  - Only channel 1 is used; `vid_addr2` is held at its reset value.
  - ISSUE sets `vid_addr1`=cur and needs 1 free slot; STORE pushes one word and advances cur by 2.
  - The same-address shortcut applies to channel 1 alone.

## Structure

- Package `sam_vid_pkg` holds:
  - the state enum `vf_state_t` (IDLE, ISSUE, WAIT, STORE);
  - `VID_ADDR_W`=25 and `VID_DATA_W`=16.
- Sub-module `sam_vid_fifo` is a synchronous first-word fall-through FIFO with parameter DEPTH and ports push/pop/flush/full/empty/free_cnt.
- The FSM and address arithmetic live in `sam_vid_fetch`.

## Test plan

- Basic line: dual mode, `line_base`=0x10000, `line_words`=4, model returns data=addr[15:0] after 20 cycles → FIFO yields 0x0000, 0x0002, 0x0004, 0x0006, then `line_done`. `vid_addr1` sequence is 0x10000, 0x10004.
- Odd tail: `line_words`=3 → exactly 3 pops. `vid_data2` from the second pair is not pushed. `line_done` fires once.
- Backpressure: `line_words`=32, `pix_rd` held low → at most FIFO_DEPTH words pushed, ISSUE stalls, no overflow. Releasing `pix_rd` completes all 32 words in order.
- Repeated line: issue the same `line_base`=0x0 with `line_words`=2 twice → the second line takes the shortcut (no WAIT; `line_done` within 4 cycles of `line_start`) and pops the same two words.
- Abort in WAIT: `line_start` during WAIT with new base 0x20000 → no stale word is ever popped; the first pop is the data for 0x20000.
- Reset mid-line: assert `reset` during STORE → the next cycle shows all outputs at their reset values and an empty FIFO. `underflow` is set by a `pix_rd` while empty and cleared by `line_start`.
